// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register write arbiter.
//   state_t           : arbiter FSM states (IDLE / GRANT / DONE)
//   RESET_VAL_DEFAULT : default reset value of the shared register
//   clog2 / idx_width : index width helpers (idx_width never returns 0)
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int RESET_VAL_DEFAULT = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
//   REQ   : per-requester level write request
//   DIN   : packed data lanes, lane i = DIN[i*WIDTH +: WIDTH]
//   GNT   : one-hot grant
//   ACK   : one-hot, single-cycle write-done pulse
//   Q     : shared register contents
//   BUSY  : arbiter is not idle
//   OWNER : index of the last requester that completed a write
// master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int PW = idx_width(NREQ);

  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] DIN;
  logic [NREQ-1:0]       GNT;
  logic [NREQ-1:0]       ACK;
  logic [WIDTH-1:0]      Q;
  logic                  BUSY;
  logic [PW-1:0]         OWNER;

  modport master (output REQ, DIN, input GNT, ACK, Q, BUSY, OWNER);
  modport slave  (input REQ, DIN, output GNT, ACK, Q, BUSY, OWNER);

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : highest-priority index this round
//   win    : one-hot winner (zero when req is zero)
//   win_idx: index of the winner
// The winner is the first set bit at or after ptr, searching upward and
// wrapping from NREQ-1 to 0. The wrap is an explicit compare so that
// non-power-of-2 NREQ works.
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx
);

  always_comb begin
    logic found;
    int   j;
    found   = 1'b0;
    j       = 0;
    win     = '0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register.
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-high reset
//   bus   : requester bus (REQ, DIN in; GNT, ACK, Q, BUSY, OWNER out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; a nonzero REQ picks a winner and grants it
// GRANT | winner holds GNT; write on REQ[W] still high, else abort
// DONE  | ACK pulse cycle; returns to IDLE unconditionally
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
  input logic                  CLK,
  input logic                  RESET,
  shared_reg_arbiter_if.slave  bus
);

  localparam int PW = idx_width(NREQ);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    widx_q, widx_d;

  logic [NREQ-1:0]  pick_win;
  logic [PW-1:0]    pick_idx;

  shared_reg_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req     (bus.REQ),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      q_q     <= RESET_VAL;
      gnt_q   <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    widx_d  = widx_q;
    case (state_q)
      IDLE: begin
        ack_d = '0;
        gnt_d = '0;
        if (|bus.REQ) begin
          gnt_d   = pick_win;
          widx_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        gnt_d = '0;
        if (bus.REQ[widx_q]) begin
          q_d     = bus.DIN[int'(widx_q)*WIDTH +: WIDTH];
          // gnt_q is exactly the winner's one-hot, so reuse it for ACK
          ack_d   = gnt_q;
          owner_d = widx_q;
          if (int'(widx_q) == NREQ - 1) ptr_d = '0;
          else                          ptr_d = widx_q + PW'(1);
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.GNT   = gnt_q;
  assign bus.ACK   = ack_q;
  assign bus.Q     = q_q;
  assign bus.BUSY  = (state_q != IDLE);
  assign bus.OWNER = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference.
module tb_shared_reg_arbiter;
  import shared_reg_arbiter_pkg::*;

  localparam int               NREQ  = 4;
  localparam int               WIDTH = 8;
  localparam logic [WIDTH-1:0] RVAL  = 8'h00;

  logic CLK = 1'b0;
  logic RESET;

  shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  shared_reg_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .RESET_VAL (RVAL)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: where a transaction is (0 none, 1 granted, 2 acked), plus
  // the architectural values the outputs should show
  int          m_phase, m_w, m_ptr, m_owner;
  logic [7:0]  m_q;
  logic [3:0]  m_gnt, m_ack;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_w = 0; m_ptr = 0; m_owner = 0;
    m_q = RVAL; m_gnt = '0; m_ack = '0;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      m_ack = '0;
      m_gnt = '0;
      if (bus.REQ != 0) begin
        m_w     = pick(bus.REQ, m_ptr);
        m_gnt   = 4'(1 << m_w);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_gnt = '0;
      if (bus.REQ[m_w]) begin
        m_q     = bus.DIN[m_w*WIDTH +: WIDTH];
        m_ack   = 4'(1 << m_w);
        m_owner = m_w;
        m_ptr   = (m_w + 1) % NREQ;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_ack   = '0;
      m_phase = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},   32'(bus.GNT),   32'(m_gnt));
    chk({tag, ".ack"},   32'(bus.ACK),   32'(m_ack));
    chk({tag, ".q"},     32'(bus.Q),     32'(m_q));
    chk({tag, ".busy"},  32'(bus.BUSY),  32'(m_phase != 0));
    chk({tag, ".owner"}, 32'(bus.OWNER), 32'(m_owner));
  endtask

  // called at posedge+1; drives inputs, advances one edge, checks at posedge+1
  task automatic cycle(input string tag, input logic [3:0] req, input logic [31:0] din);
    bus.REQ = req;
    bus.DIN = din;
    @(posedge CLK);
    model_step();
    #1;
    check_all(tag);
  endtask

  // asynchronous pulse placed between clock edges
  task automatic do_reset(input string tag);
    #3 RESET = 1'b1;
    #1;
    chk({tag, ".rq"},    32'(bus.Q),    32'(RVAL));
    chk({tag, ".rgnt"},  32'(bus.GNT),  32'(0));
    chk({tag, ".rack"},  32'(bus.ACK),  32'(0));
    chk({tag, ".rbusy"}, 32'(bus.BUSY), 32'(0));
    model_reset();
    #2 RESET = 1'b0;
    @(posedge CLK);
    model_step();
    #1;
    check_all({tag, ".post"});
  endtask

  logic [3:0]  hold;
  logic [31:0] din;
  int          ord[$];
  int          qs[$];
  int          tk[$];

  initial begin
    RESET   = 1'b1;
    bus.REQ = '0;
    bus.DIN = '0;
    model_reset();
    #1;
    check_all("init");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // preload Q with A5, then reset between edges
    din = 32'h000000A5;
    cycle("pre1", 4'b0001, din);
    cycle("pre2", 4'b0001, din);
    chk("pre.q", 32'(bus.Q), 32'h0000_00A5);
    cycle("pre3", 4'b0000, din);
    do_reset("rst_a5");

    // single request on lane 2
    din = 32'h003C0000;
    cycle("one1", 4'b0100, din);
    chk("one.gnt", 32'(bus.GNT), 32'h4);
    cycle("one2", 4'b0100, din);
    chk("one.q",     32'(bus.Q),     32'h3C);
    chk("one.ack",   32'(bus.ACK),   32'h4);
    chk("one.owner", 32'(bus.OWNER), 32'd2);
    cycle("one3", 4'b0000, din);
    chk("one.ack_lo", 32'(bus.ACK), 32'h0);
    cycle("one4", 4'b0000, din);

    // full contention from PTR=0, each requester leaves after its ACK
    do_reset("rst_cont");
    din  = 32'h13121110;
    hold = 4'b1111;
    for (int c = 0; c < 14; c++) begin
      cycle("cont", hold, din);
      if (bus.ACK != 0) begin
        for (int i = 0; i < NREQ; i++) if (bus.ACK[i]) ord.push_back(i);
        qs.push_back(int'(bus.Q));
        tk.push_back(c);
        hold = hold & ~bus.ACK;
      end
    end
    chk("cont.n", 32'(ord.size()), 32'd4);
    for (int i = 0; i < ord.size() && i < 4; i++) begin
      chk("cont.ord", 32'(ord[i]), 32'(i));
      chk("cont.q",   32'(qs[i]),  32'(8'h10 + i));
      if (i > 0) chk("cont.gap", 32'(tk[i] - tk[i-1]), 32'd3);
    end

    // wrap: write from requester 2 leaves PTR=3, then 3 beats 0
    din = 32'h33221100;
    cycle("wr1", 4'b0100, din);
    cycle("wr2", 4'b0100, din);
    cycle("wr3", 4'b0000, din);
    cycle("wr4", 4'b0000, din);
    ord.delete();
    hold = 4'b1001;
    for (int c = 0; c < 9; c++) begin
      cycle("wrap", hold, din);
      if (bus.ACK != 0) begin
        for (int i = 0; i < NREQ; i++) if (bus.ACK[i]) ord.push_back(i);
        hold = hold & ~bus.ACK;
      end
    end
    chk("wrap.n", 32'(ord.size()), 32'd2);
    if (ord.size() == 2) begin
      chk("wrap.first",  32'(ord[0]), 32'd3);
      chk("wrap.second", 32'(ord[1]), 32'd0);
    end
    // PTR should now be 1: of {0,1}, requester 1 wins
    cycle("wrp1", 4'b0011, din);
    chk("wrap.ptr1", 32'(bus.GNT), 32'h2);
    cycle("wrp2", 4'b0011, din);
    cycle("wrp3", 4'b0000, din);
    cycle("wrp4", 4'b0000, din);

    // abort: PTR=2, requester 1 granted then drops
    cycle("ab1", 4'b0010, din);
    chk("ab.gnt", 32'(bus.GNT), 32'h2);
    cycle("ab2", 4'b0000, din);
    chk("ab.ack",  32'(bus.ACK),  32'h0);
    chk("ab.busy", 32'(bus.BUSY), 32'h0);
    chk("ab.q",    32'(bus.Q),    32'h11);
    cycle("ab3", 4'b0110, din);
    chk("ab.ptr", 32'(bus.GNT), 32'h4);
    cycle("ab4", 4'b0110, din);
    cycle("ab5", 4'b0000, din);
    cycle("ab6", 4'b0000, din);

    // reset while granting requester 0, then a fresh request
    din = 32'h000000C7;
    cycle("rg1", 4'b0001, din);
    chk("rg.gnt", 32'(bus.GNT), 32'h1);
    do_reset("rst_grant");
    chk("rg.regnt", 32'(bus.GNT), 32'h1);
    cycle("rg2", 4'b0001, din);
    chk("rg.q",   32'(bus.Q),   32'hC7);
    chk("rg.ack", 32'(bus.ACK), 32'h1);
    cycle("rg3", 4'b0000, din);

    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 600; c++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      cycle("rnd", r, $urandom);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
